control_unit: RTL and testbench

- Sequencer that sits directly upstream of the ALU in the Salamander-4 datapath.
- Fetches instructions from a synchronous instruction memory and reads operands from a synchronous data memory.
- Drives the ALU's CE, OP_CODE, operand and carry inputs, then latches the ALU result into the accumulator and carry/zero flags.
- Handles ST, JMP, RTN and HLT itself; these opcodes never use the ALU result.

---
 rtl/salamander_pkg.sv | 28 ++
 rtl/cu_decoder.sv | 36 +++
 rtl/control_unit.sv | 109 ++++++++++
 tb/tb_control_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared Salamander-4 definitions: ALU opcode encoding and the control unit state type.
package salamander_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_DEC = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;
  localparam logic [3:0] OP_SHL = 4'd11;
  localparam logic [3:0] OP_SHR = 4'd12;
  localparam logic [3:0] OP_JMP = 4'd13;
  localparam logic [3:0] OP_RTN = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } cu_state_t;

endpackage

// File: rtl/cu_decoder.sv
// Opcode-to-control decode for the control unit; outputs are only acted on in EXECUTE.
module cu_decoder
  import salamander_pkg::*;
(
  input  logic [3:0] op_code,
  output logic       acc_we,
  output logic       carry_we,
  output logic       mem_we,
  output logic       jump,
  output logic       ret,
  output logic       halt
);

  always_comb begin
    acc_we   = 1'b0;
    carry_we = 1'b0;
    mem_we   = 1'b0;
    jump     = 1'b0;
    ret      = 1'b0;
    halt     = 1'b0;
    case (op_code)
      OP_ADD, OP_SUB: begin
        acc_we   = 1'b1;
        carry_we = 1'b1;
      end
      OP_LD, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR:
        acc_we = 1'b1;
      OP_ST:  mem_we = 1'b1;
      OP_JMP: jump   = 1'b1;
      OP_RTN: ret    = 1'b1;
      OP_HLT: halt   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Salamander-4 sequencer: fetch/decode/execute around an external ALU and two synchronous memories.
//   state   | meaning
//   FETCH   | pc on instr_addr, memory read in flight
//   DECODE  | latch ir, operand address presented to data memory
//   EXECUTE | ALU enabled, results/pc/write committed
//   HALT    | frozen until rst
module control_unit
  import salamander_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   instr_addr,
  input  logic [ADDR_W+3:0]   instr_data,
  output logic [ADDR_W-1:0]   data_addr,
  input  logic [SIZE-1:0]     data_rd_data,
  output logic                data_wr_en,
  output logic [SIZE-1:0]     data_wr_data,
  output logic                alu_ce,
  output logic [3:0]          alu_op_code,
  output logic [SIZE-1:0]     alu_left,
  output logic [SIZE-1:0]     alu_right,
  output logic                alu_carry_in,
  input  logic                alu_carry_out,
  input  logic [SIZE-1:0]     alu_op_out,
  output logic [SIZE-1:0]     acc,
  output logic                carry_flag,
  output logic                zero_flag,
  output logic                halted
);

  cu_state_t         state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link;
  logic [ADDR_W+3:0] ir;
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic              in_exec;
  logic              acc_we, carry_we, mem_we, jump, ret, halt;

  assign ir_op   = ir[ADDR_W+3:ADDR_W];
  assign ir_addr = ir[ADDR_W-1:0];
  assign pc_inc  = pc + ADDR_W'(1);

  cu_decoder u_decoder (
    .op_code  (ir_op),
    .acc_we   (acc_we),
    .carry_we (carry_we),
    .mem_we   (mem_we),
    .jump     (jump),
    .ret      (ret),
    .halt     (halt)
  );

  // Strobes are masked by rst so a reset landing on an ST execute never writes memory.
  assign in_exec      = (state == EXECUTE) && !rst;
  assign instr_addr   = pc;
  assign data_addr    = (state == DECODE) ? instr_data[ADDR_W-1:0] : ir_addr;
  assign data_wr_en   = in_exec && mem_we;
  assign data_wr_data = acc;
  assign alu_ce       = in_exec;
  assign alu_op_code  = in_exec ? ir_op : OP_NOP;
  assign alu_left     = acc;
  assign alu_right    = data_rd_data;
  assign alu_carry_in = carry_flag;
  assign halted       = (state == HALT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= '0;
      link       <= '0;
      ir         <= '0;
      acc        <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          ir    <= instr_data;
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (acc_we) begin
            acc       <= alu_op_out;
            zero_flag <= (alu_op_out == '0);
          end
          if (carry_we) carry_flag <= alu_carry_out;
          if (jump) begin
            link <= pc_inc;
            pc   <= ir_addr;
          end else if (ret) begin
            pc <= link;
          end else if (!halt) begin
            pc <= pc_inc;
          end
          state <= halt ? HALT : FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: memories and ALU are emulated here, and an instruction-level
// reference model predicts every output on every cycle.
module tb_control_unit;
  import salamander_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [3:0] data_addr;
  logic [7:0] data_rd_data;
  logic       data_wr_en;
  logic [7:0] data_wr_data;
  logic       alu_ce;
  logic [3:0] alu_op_code;
  logic [7:0] alu_left, alu_right;
  logic       alu_carry_in, alu_carry_out;
  logic [7:0] alu_op_out;
  logic [7:0] acc;
  logic       carry_flag, zero_flag, halted;

  int total = 0;
  int bad   = 0;

  logic [7:0] imem  [16];
  logic [7:0] dmem  [16];
  logic [7:0] dinit [16];
  logic [7:0] m_mem [16];
  logic [3:0] fetch_q[$];
  logic [8:0] junk = '0;
  logic [8:0] alu_res;

  control_unit #(.SIZE(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .data_addr(data_addr), .data_rd_data(data_rd_data),
    .data_wr_en(data_wr_en), .data_wr_data(data_wr_data),
    .alu_ce(alu_ce), .alu_op_code(alu_op_code),
    .alu_left(alu_left), .alu_right(alu_right),
    .alu_carry_in(alu_carry_in), .alu_carry_out(alu_carry_out),
    .alu_op_out(alu_op_out),
    .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    case (op)
      OP_LD:  return {1'b0, b};
      OP_ADD: return {1'b0, a} + {1'b0, b} + 9'(cin);
      OP_SUB: return {1'b0, a} - {1'b0, b} - 9'(cin);
      OP_INC: return {1'b0, a + 8'd1};
      OP_DEC: return {1'b0, a - 8'd1};
      OP_AND: return {1'b0, a & b};
      OP_OR:  return {1'b0, a | b};
      OP_XOR: return {1'b0, a ^ b};
      OP_NOT: return {1'b0, ~a};
      OP_SHL: return {1'b0, a << 1};
      OP_SHR: return {1'b0, a >> 1};
      default: return {1'b0, a};
    endcase
  endfunction

  // ALU stand-in: garbage whenever CE is low, and a garbage carry for non-arithmetic ops.
  always @(negedge clk) junk <= 9'($urandom);
  always_comb begin
    alu_res = alu_ref(alu_op_code, alu_left, alu_right, alu_carry_in);
    if (alu_ce) begin
      alu_op_out    = alu_res[7:0];
      alu_carry_out = (alu_op_code == OP_ADD || alu_op_code == OP_SUB) ? alu_res[8] : junk[8];
    end else begin
      alu_op_out    = junk[7:0];
      alu_carry_out = junk[8];
    end
  end

  always @(posedge clk) begin
    instr_data   <= imem[instr_addr];
    data_rd_data <= dmem[data_addr];
    if (ld) dmem <= dinit;
    else if (data_wr_en) dmem[data_addr] <= data_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model: each instruction is three cycles, then ISA semantics apply.
  logic [3:0] m_pc, m_link;
  logic [7:0] m_acc, m_ir;
  logic       m_c, m_z, m_halt;
  int         phase;

  initial begin : model
    logic       exp_ce;
    logic [3:0] op, a;
    logic [8:0] r;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_wr_en", data_wr_en, 1'b0);
        check("rst_alu_ce", alu_ce, 1'b0);
        check("rst_halted", halted, 1'b0);
        if (ld) m_mem = dinit;
        m_pc = '0; m_link = '0; m_acc = '0; m_ir = '0;
        m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; phase = 0;
      end else begin
        exp_ce = !m_halt && phase == 2;
        op = m_ir[7:4];
        a  = m_ir[3:0];
        check("instr_addr", instr_addr, m_pc);
        check("acc", acc, m_acc);
        check("carry_flag", carry_flag, m_c);
        check("zero_flag", zero_flag, m_z);
        check("halted", halted, m_halt);
        check("wr_data", data_wr_data, m_acc);
        check("alu_left", alu_left, m_acc);
        check("alu_carry_in", alu_carry_in, m_c);
        check("alu_ce", alu_ce, exp_ce);
        check("alu_op_code", alu_op_code, exp_ce ? op : OP_NOP);
        check("wr_en", data_wr_en, exp_ce && op == OP_ST);
        if (!m_halt && phase == 1) check("data_addr_dec", data_addr, imem[m_pc][3:0]);
        else                       check("data_addr", data_addr, a);
        if (exp_ce) check("alu_right", alu_right, m_mem[a]);
        if (!m_halt) begin
          if (phase == 0) phase = 1;
          else if (phase == 1) begin
            m_ir = imem[m_pc];
            phase = 2;
          end else begin
            phase = 0;
            r = alu_ref(op, m_acc, m_mem[a], m_c);
            case (op)
              OP_ADD, OP_SUB: begin
                m_acc = r[7:0]; m_c = r[8]; m_z = (r[7:0] == 8'h00); m_pc = m_pc + 4'd1;
              end
              OP_LD, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                m_acc = r[7:0]; m_z = (r[7:0] == 8'h00); m_pc = m_pc + 4'd1;
              end
              OP_ST:  begin m_mem[a] = m_acc; m_pc = m_pc + 4'd1; end
              OP_JMP: begin m_link = m_pc + 4'd1; m_pc = a; end
              OP_RTN: m_pc = m_link;
              OP_HLT: m_halt = 1'b1;
              default: m_pc = m_pc + 4'd1;
            endcase
          end
        end
      end
    end
  end

  task automatic reset_on(input bit cmp_mem);
    @(posedge clk); #1;
    rst = 1'b1;
    if (cmp_mem) for (int i = 0; i < 16; i++) check("dmem_vs_model", dmem[i], m_mem[i]);
    for (int i = 0; i < 16; i++) begin
      imem[i]  = {OP_HLT, 4'h0};
      dinit[i] = 8'h00;
    end
  endtask

  task automatic reset_off();
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run(input int max_cyc, output int cyc);
    fetch_q.delete();
    cyc = max_cyc;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (halted === 1'b1) begin
        cyc = n;
        break;
      end
      if (n % 3 == 0) fetch_q.push_back(instr_addr);
    end
  endtask

  function automatic logic [3:0] qget(input int k);
    logic [3:0] v;
    v = 'x;
    if (fetch_q.size() > k) v = fetch_q[k];
    return v;
  endfunction

  initial begin : driver
    int cyc, changes;
    logic [32:0] snap;
    logic [3:0] op;

    reset_on(1'b0);
    dinit[5] = 8'h0F; dinit[6] = 8'hF1; dinit[7] = 8'hAA;
    imem[0] = 8'h15; imem[1] = 8'h36; imem[2] = 8'h27; imem[3] = 8'hF0;
    reset_off();
    run(40, cyc);
    check("t1_halt_cycles", cyc, 12);
    check("t1_acc", acc, 8'h00);
    check("t1_carry", carry_flag, 1'b1);
    check("t1_zero", zero_flag, 1'b1);
    check("t1_mem7", dmem[7], 8'h00);
    check("t1_pc", instr_addr, 4'd3);
    snap = {acc, carry_flag, zero_flag, instr_addr, data_addr, alu_ce, data_wr_en,
            halted, alu_op_code, data_wr_data};
    changes = 0;
    repeat (20) begin
      @(negedge clk);
      if ({acc, carry_flag, zero_flag, instr_addr, data_addr, alu_ce, data_wr_en,
           halted, alu_op_code, data_wr_data} !== snap) changes++;
    end
    check("halt_hold_changes", changes, 0);

    reset_on(1'b1);
    dinit[0] = 8'hFF; dinit[1] = 8'h01; dinit[2] = 8'h10; dinit[3] = 8'h0F;
    imem[0] = 8'h10; imem[1] = 8'h31; imem[2] = 8'h12; imem[3] = 8'h43; imem[4] = 8'hF0;
    reset_off();
    run(40, cyc);
    check("t2_halt_cycles", cyc, 15);
    check("t2_acc", acc, 8'h00);
    check("t2_borrow", carry_flag, 1'b0);
    check("t2_zero", zero_flag, 1'b1);

    reset_on(1'b1);
    imem[0] = 8'h00; imem[1] = 8'h00; imem[2] = 8'hD9; imem[9] = 8'hE0; imem[3] = 8'hF0;
    reset_off();
    run(40, cyc);
    check("t3_halt_cycles", cyc, 15);
    check("t3_fetch_jmp", qget(3), 4'd9);
    check("t3_fetch_rtn", qget(4), 4'd3);
    check("t3_pc", instr_addr, 4'd3);

    reset_on(1'b1);
    imem[0] = 8'hDF; imem[15] = 8'h00;
    reset_off();
    run(9, cyc);
    check("t4a_fetch_15", qget(1), 4'd15);
    check("t4a_wrap", qget(2), 4'd0);

    reset_on(1'b1);
    imem[0] = 8'hDF; imem[15] = 8'hD4; imem[4] = 8'hE0;
    reset_off();
    run(12, cyc);
    check("t4b_fetch_4", qget(2), 4'd4);
    check("t4b_link_wrap", qget(3), 4'd0);

    reset_on(1'b1);
    dinit[5] = 8'h5A; dinit[7] = 8'h33;
    imem[0] = 8'h15; imem[1] = 8'h27;
    reset_off();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_wr_en", data_wr_en, 1'b0);
    check("t5_acc_before", acc, 8'h5A);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_pc", instr_addr, 4'd0);
    check("t5_acc", acc, 8'h00);
    check("t5_mem7", dmem[7], 8'h33);

    for (int r = 0; r < 10; r++) begin
      reset_on(1'b1);
      for (int i = 0; i < 16; i++) begin
        dinit[i] = 8'($urandom);
        op = ($urandom_range(0, 19) == 0) ? OP_HLT : 4'($urandom_range(0, 14));
        imem[i] = {op, 4'($urandom)};
      end
      reset_off();
      run($urandom_range(30, 300), cyc);
    end
    reset_on(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
